// File: rtl/ff_en_stim_chk_if.sv
// Sequencer <-> ff_en DUT link: readiness, stimulus data/enable and the
// DUT's registered output coming back for checking.
interface ff_en_stim_chk_if #(
    parameter int unsigned WIDTH = 10
);
    logic             rdy;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] d_in;
    logic             d_en;

    // Sequencer side: drives stimulus, observes rdy and d_out.
    modport master (
        input  rdy,
        input  d_out,
        output d_in,
        output d_en
    );

    // DUT side: consumes stimulus, reports rdy and d_out.
    modport slave (
        output rdy,
        output d_out,
        input  d_in,
        input  d_en
    );
endinterface

// File: rtl/ff_en_stim_chk.sv
// Self-checking stimulus sequencer for the ff_en test DUT.
// After rdy is seen it plays an LFSR data stream with a fixed enable pattern,
// tracks a golden copy of the enabled register and counts d_out mismatches.
// Optional build macro FF_EN_STIM_STOP_ON_ERR_EN: finish at the first mismatch
// instead of running the whole sequence.
module ff_en_stim_chk #(
    parameter int unsigned      WIDTH       = 10,
    parameter int unsigned      NUM_VECTORS = 64,
    parameter int unsigned      START_DELAY = 1,
    parameter logic [WIDTH-1:0] SEED        = 10'h155
) (
    input  logic                   clock,
    input  logic                   rst,
    ff_en_stim_chk_if.master       bus,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_cnt,
    output logic [9:0]             first_err_idx
);

    localparam int unsigned      IDX_W    = 10;
    localparam int unsigned      DLY_W    = 8;
    localparam int unsigned      ERR_W    = 8;
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
    localparam logic [IDX_W-1:0] NO_ERR   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [IDX_W-1:0] idx;
    logic [DLY_W-1:0] dly_cnt;
    logic             drain_cnt;
    logic [WIDTH-1:0] exp_data;
    logic             exp_vld;
    logic [IDX_W-1:0] exp_idx;

    logic [WIDTH-1:0] lfsr_next_c;
    logic [IDX_W-1:0] idx_inc_c;
    logic             chk_act_c;
    logic             mism_c;
    logic [ERR_W-1:0] err_next_c;
    logic             abort_c;

    // LFSR step, next vector index, compare and abort decode.
    always_comb begin
        lfsr_next_c = {lfsr[WIDTH-2:0], lfsr[9] ^ lfsr[6]};
        idx_inc_c   = idx + IDX_W'(1);
        chk_act_c   = ((state == RUN) || (state == DRAIN)) && exp_vld;
        mism_c      = chk_act_c && (bus.d_out != exp_data);
        err_next_c  = err_cnt;
        if (mism_c && (err_cnt != ERR_MAX)) begin
            err_next_c = err_cnt + ERR_W'(1);
        end
        abort_c = ((state == DELAY) || (state == RUN) || (state == DRAIN)) && !bus.rdy;
    end

    // Sequencer FSM with registered stimulus, golden model and result outputs.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.d_in      <= '0;
            bus.d_en      <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
            lfsr          <= SEED_EFF;
            idx           <= '0;
            dly_cnt       <= '0;
            drain_cnt     <= 1'b0;
            exp_data      <= '0;
            exp_vld       <= 1'b0;
            exp_idx       <= '0;
        end else if (abort_c) begin
            // rdy lost mid-sequence: drop everything and wait for rdy again.
            state         <= IDLE;
            bus.d_en      <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR;
            lfsr          <= SEED_EFF;
            idx           <= '0;
            dly_cnt       <= '0;
            drain_cnt     <= 1'b0;
            exp_vld       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.d_en <= 1'b0;
                    if (bus.rdy) begin
                        dly_cnt <= '0;
                        if (START_DELAY == 0) begin
                            state    <= RUN;
                            idx      <= '0;
                            bus.d_in <= lfsr;
                            bus.d_en <= 1'b1;
                            lfsr     <= lfsr_next_c;
                        end else begin
                            state <= DELAY;
                        end
                    end
                end

                DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        // Vector 0 is presented in the first RUN cycle.
                        state    <= RUN;
                        idx      <= '0;
                        bus.d_in <= lfsr;
                        bus.d_en <= 1'b1;
                        lfsr     <= lfsr_next_c;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end

                RUN, DRAIN: begin
                    // Check the value the DUT captured on an earlier edge.
                    err_cnt <= err_next_c;
                    if (mism_c && (err_cnt == '0)) begin
                        first_err_idx <= exp_idx;
                    end
                    // Golden register follows the enable seen by the DUT.
                    if (bus.d_en) begin
                        exp_data <= bus.d_in;
                        exp_vld  <= 1'b1;
                        exp_idx  <= idx;
                    end
`ifdef FF_EN_STIM_STOP_ON_ERR_EN
                    if (mism_c && (err_cnt == '0)) begin
                        // Freeze stimulus at the first mismatch and finish.
                        state    <= DONE;
                        done     <= 1'b1;
                        pass     <= 1'b0;
                        bus.d_en <= 1'b0;
                    end else
`endif
                    if (state == RUN) begin
                        if (idx == LAST_IDX) begin
                            state     <= DRAIN;
                            bus.d_en  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end else begin
                            idx      <= idx_inc_c;
                            bus.d_in <= lfsr;
                            bus.d_en <= (idx_inc_c[1:0] != 2'b11);
                            lfsr     <= lfsr_next_c;
                        end
                    end else begin
                        bus.d_en <= 1'b0;
                        if (drain_cnt) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0);
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Sticky result until reset; rdy no longer matters.
                    bus.d_en <= 1'b0;
                    done     <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    bus.d_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ff_en_stim_chk.md
Name: ff_en_stim_chk

Overview:
- Self-checking stimulus sequencer that sits directly upstream of the on-FPGA ff_en test DUT.
- Waits for the DUT's rdy, then drives a deterministic LFSR data stream on d_in with a fixed d_en pattern.
- Keeps a golden model of the enabled register, compares it against the DUT's d_out every cycle, and reports done, pass and an error count to the board test harness.

Parameters:
WIDTH, 10, data width of d_in/d_out/LFSR (LFSR taps defined for 10 only)
NUM_VECTORS, 64, number of stimulus cycles in RUN (1..1023)
START_DELAY, 1, idle cycles between rdy seen high and first vector (0..255)
SEED, 10'h155, LFSR seed; an all-zero seed is replaced by 10'h001

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
rdy  in  1  DUT configured/ready
d_out  in  WIDTH  DUT registered output
d_in  out  WIDTH  stimulus data to DUT
d_en  out  1  stimulus enable to DUT
done  out  1  sequence finished (sticky until reset)
pass  out  1  valid only when done=1; 1 = zero mismatches
err_cnt  out  8  mismatch count, saturates at 8'hFF
first_err_idx  out  10  vector index of first mismatch; 10'h3FF if none

Behaviour:
- Reset (async, rst=0): state=IDLE, d_in=0, d_en=0, done=0, pass=0, err_cnt=0, first_err_idx=10'h3FF, lfsr=SEED (or 10'h001), idx=0, exp=0, exp_vld=0.
- States: IDLE -> DELAY -> RUN -> DRAIN -> DONE.
- IDLE: d_en=0. When rdy=1, go to DELAY with dly_cnt=0. If START_DELAY=0, go straight to RUN.
- DELAY: count START_DELAY cycles, then RUN.
- RUN, one vector per cycle, index i=0..NUM_VECTORS-1:
  - d_in = lfsr.
  - d_en = 0 when i[1:0]==2'b11, else 1.
  - lfsr advances every cycle: lfsr <= {lfsr[8:0], lfsr[9]^lfsr[6]}.
  - After the last vector, go to DRAIN.
- DRAIN: 2 cycles with d_en=0 and d_in held, then DONE.
- DONE: d_en=0, done=1, pass=(err_cnt==0). Holds until reset; rdy is ignored.
- Golden model: at each rising edge where the driven d_en=1, exp <= d_in and exp_vld <= 1. The DUT captures on the same edge, so d_out must equal exp in the following cycle.
- Compare:
  - Active every cycle in RUN and DRAIN when exp_vld=1.
  - The comparison is sampled at the rising edge.
  - A mismatch increments err_cnt (saturating at 8'hFF).
  - first_err_idx is written only on the first mismatch, with the index of the vector whose capture is being checked.
- rdy falls during DELAY/RUN/DRAIN: abort to IDLE.
  - d_en=0; lfsr, idx, exp_vld reset.
  - err_cnt and first_err_idx are cleared.
  - done stays 0; the sequence restarts when rdy returns high.
- rst asserted mid-sequence: immediate async return to reset values. No partial result is retained.
- Overall latency: rdy seen high -> first d_en=1 is START_DELAY+1 cycles. done rises NUM_VECTORS+2 cycles after entering RUN.

Optional Feature:
- Macro: FF_EN_STIM_STOP_ON_ERR_EN.
- Defined: the first mismatch forces a transition to DONE on the next edge.
  - d_in and d_en are frozen at their values at the time of the mismatch, except d_en is forced to 0.
  - pass=0, err_cnt=1.
- Undefined: the full sequence always runs and all mismatches are counted.

Test Plan:
1. Reset then rdy=1 at t0, defaults -> after 2 cycles d_in=10'h155, d_en=1; next cycle d_in=10'h2AB, d_en=1; vector 3 has d_en=0.
2. Ideal ff_en model on d_out, NUM_VECTORS=64 -> done=1 after 66 RUN+DRAIN cycles, pass=1, err_cnt=0, first_err_idx=10'h3FF.
3. d_out bit 0 stuck at 0 -> pass=0, err_cnt>0, first_err_idx = first enabled vector with lfsr[0]=1 (vector 0, 10'h155).
4. rdy dropped to 0 at RUN vector 10, raised again 5 cycles later -> d_en=0 while low, sequence restarts from d_in=10'h155, final pass=1.
5. rst pulsed low mid-RUN -> all outputs return to reset values asynchronously, before the next clock edge.
6. With FF_EN_STIM_STOP_ON_ERR_EN and a mismatch injected at vector 5 -> done=1 one cycle later, err_cnt=1, pass=0, d_en=0.
